uart_rx_fifo: RTL

- Parametrised UART receive front end: 2-flop input synchroniser, mid-bit sampling with start-bit validation, 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits.
- Received frames and their per-frame error flags are buffered in a show-ahead FIFO.
- Output uses a valid/ready handshake to the consumer; a sticky overrun flag reports frames lost because the FIFO was full.

---
 rtl/uart_rx_fifo.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop sync, mid-bit sampling, 5-9 data bits, optional parity, 1-2 stop bits) feeding a show-ahead frame FIFO.
// Entry visible the cycle after the final stop sample; valid/ready pop; a frame arriving at a full FIFO is dropped and flags sticky overrun.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock_12MHz,
    input  logic                 reset,
    input  logic                 uart_rx_wild,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 data_valid,
    input  logic                 ready,
    output logic                 overrun,
    input  logic                 overrun_clear
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == 2);
    localparam logic             HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    logic                 sync1, rx_sync;
    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, idx_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par_err, pe_n;
    logic                 frm_err, fe_n;
    logic                 stop_idx, stop_n;
    logic                 expire, push;
    logic [ENT_W-1:0]     push_dat;

    always_ff @(posedge clock_12MHz) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync1   <= uart_rx_wild;
            rx_sync <= sync1;
        end
    end

    always_ff @(posedge clock_12MHz) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= idx_n;
            shreg    <= sh_n;
            par_err  <= pe_n;
            frm_err  <= fe_n;
            stop_idx <= stop_n;
        end
    end

    assign expire = (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        sh_n    = shreg;
        pe_n    = par_err;
        fe_n    = frm_err;
        stop_n  = stop_idx;
        push    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_sync) begin
                    cnt_n   = HALF_BIT;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rx_sync) begin
                    cnt_n   = FULL_BIT;
                    idx_n   = '0;
                    pe_n    = 1'b0;
                    fe_n    = 1'b0;
                    stop_n  = 1'b0;
                    state_n = S_DATA;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    sh_n  = {rx_sync, shreg[DATA_BITS-1:1]};
                    cnt_n = FULL_BIT;
                    idx_n = bit_idx + 1'b1;
                    if (bit_idx == LAST_IDX)
                        state_n = HAS_PAR ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n   = FULL_BIT;
                    pe_n    = ((^shreg) ^ rx_sync) != ODD_PAR;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    fe_n  = frm_err | ~rx_sync;
                    cnt_n = FULL_BIT;
                    if (stop_idx == LAST_STOP) begin
                        push    = 1'b1;
                        // a low final stop sample means a break: wait for idle before hunting again
                        state_n = rx_sync ? S_IDLE : S_BRK;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            S_BRK: begin
                if (rx_sync)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign push_dat = {fe_n, par_err, shreg};

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [PTR_W:0]   count, count_n, remain;
    logic [ENT_W-1:0] head, head_n;
    logic             full, pop, push_ok, drop;

    assign data_valid = (count != '0);
    assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = data_valid & ready;
    assign push_ok    = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign rd_nxt     = rd_ptr + PTR_W'(pop);
    assign remain     = count - (PTR_W+1)'(pop);
    assign count_n    = remain + (PTR_W+1)'(push_ok);
    // head is registered so the outputs hold their last value once the FIFO drains
    assign head_n     = (remain == '0) ? push_dat : mem[rd_nxt];

    always_ff @(posedge clock_12MHz) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock_12MHz) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            head    <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_nxt;
            count   <= count_n;
            if (count_n != '0)
                head <= head_n;
            overrun <= drop | (overrun & ~overrun_clear);
        end
    end

    assign data         = head[DATA_BITS-1:0];
    assign parity_error = head[DATA_BITS];
    assign frame_error  = head[DATA_BITS+1];
endmodule
